// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: one-hot T-state ring plus combinational control-word decode.
// Optional build macro SEQ_EARLY_END_EN ends each instruction after its last active step.
module sap_control_sequencer #(
    parameter int OP_WIDTH = 4,
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                carry,
    input  logic                zero,
    output logic [T_STATES-1:0] tstate,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ram_in,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                sum,
    output logic                sub,
    output logic                alu_out,
    output logic                fi,
    output logic                out_load,
    output logic                halt
);

    if (T_STATES != 6) begin : g_bad_t_states
        $error("sap_control_sequencer: T_STATES must be 6");
    end

    localparam logic [T_STATES-1:0] T1 = T_STATES'(1);
    localparam logic [T_STATES-1:0] T2 = T_STATES'(2);
    localparam logic [T_STATES-1:0] T3 = T_STATES'(4);
    localparam logic [T_STATES-1:0] T4 = T_STATES'(8);
    localparam logic [T_STATES-1:0] T5 = T_STATES'(16);
    localparam logic [T_STATES-1:0] T6 = T_STATES'(32);

    localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_STA = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_LDI = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_JC  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_JZ  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_OUT = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(15);

    // run is a level enable, not a handshake: while run=1 and halt=0 the ring
    // advances every clk; while run=0 it freezes and the control word is held at 0.
    logic active;
    logic advance;
    logic last_step;

    assign active  = rst && run && !halt;
    assign advance = run && !halt;

`ifdef SEQ_EARLY_END_EN
    always_comb begin
        last_step = 1'b0;
        case (opcode)
            OP_LDA, OP_STA: last_step = (tstate == T5);
            OP_ADD, OP_SUB: last_step = (tstate == T6);
            default:        last_step = (tstate == T4);
        endcase
    end
`else
    always_comb begin
        last_step = (tstate == T6);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tstate <= T1;
            halt   <= 1'b0;
        end else if (advance) begin
            if (tstate == T4 && opcode == OP_HLT) begin
                halt <= 1'b1;
            end else if (last_step) begin
                tstate <= T1;
            end else begin
                tstate <= {tstate[T_STATES-2:0], tstate[T_STATES-1]};
            end
        end
    end

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        sum      = 1'b0;
        sub      = 1'b0;
        alu_out  = 1'b0;
        fi       = 1'b0;
        out_load = 1'b0;
        if (active) begin
            case (tstate)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T2: begin
                    pc_inc = 1'b1;
                end
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out   = 1'b1;
                            mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        // Flags are read live here, so a late flag change is followed.
                        OP_JC: begin
                            ir_out  = carry;
                            pc_load = carry;
                        end
                        OP_JZ: begin
                            ir_out  = zero;
                            pc_load = zero;
                        end
                        OP_OUT: begin
                            a_out    = 1'b1;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_load  = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        fi      = 1'b1;
                        sum     = (opcode == OP_ADD);
                        sub     = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
